rx_char_buffer: RTL
===================

RX_CHAR_BUFFER -- requirements
Module: rx_char_buffer

Interface
REQ-001 Parameter: DEPTH, 8, number of character entries; power of 2, range 2..16.
REQ-002 Parameter: DATA_W, 8, character width in bits.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: rx_valid  input  1  one-cycle strobe from the receiver marking a completed character.
REQ-006 Port: rx_data  input  DATA_W  received character, valid only with rx_valid.
REQ-007 Port: rx_stop_bit  input  1  sampled stop bit, valid with rx_valid; 0 means framing error.
REQ-008 Port: rd_req  input  1  level from the processor PIO; each 0->1 transition pops one entry.
REQ-009 Port: clr_overrun  input  1  clears the sticky overrun flag.
REQ-010 Port: parallel_out  output  DATA_W  head character (show-ahead).
REQ-011 Port: char_received  output  1  high while at least one entry is held.
REQ-012 Port: framing_err  output  1  stop-bit error tag of the head entry.
REQ-013 Port: count  output  $clog2(DEPTH)+1  number of entries held.
REQ-014 Port: full  output  1  count == DEPTH.
REQ-015 Port: overrun  output  1  sticky lost-character flag; present only with RX_OVERRUN_FLAG_EN.

Function
REQ-016 Storage SHALL be a DEPTH-entry circular FIFO of {rx_stop_bit, rx_data}, with write and read pointers that wrap from DEPTH-1 to 0.
REQ-017 Pop SHALL be a single-cycle pulse, generated by registering rd_req and detecting rd_req & ~rd_req_q.
REQ-018 A push SHALL occur on rx_valid when not full, or when full and a pop occurs in the same cycle.
REQ-019 A pop SHALL occur on a pop pulse only when not empty; a pop on empty SHALL be ignored with no pointer change.
REQ-020 When rx_valid and a pop pulse coincide while empty: push only; the pop SHALL be discarded, not deferred.
REQ-021 When push and pop coincide while partially filled: both occur and count is unchanged.
REQ-022 When rx_valid arrives while full with no pop: the character SHALL be dropped, with no storage or pointer change.
REQ-023 A written character SHALL be visible on parallel_out one cycle after the rx_valid edge if the FIFO was empty (latency 1).
REQ-024 parallel_out and framing_err SHALL read 0 while empty.
REQ-025 Status FSM states: EMPTY, PARTIAL, FULL.
REQ-026 EMPTY->PARTIAL on push; PARTIAL->EMPTY on pop with count==1 and no push; PARTIAL->FULL on push with count==DEPTH-1 and no pop; FULL->PARTIAL on pop with no push; all other cases hold.
REQ-027 char_received SHALL equal (state != EMPTY); full SHALL equal (state == FULL); both SHALL be registered.
REQ-028 count SHALL be incremented/decremented per push/pop and never exceed DEPTH or underflow.

Reset
REQ-029 On rst: pointers=0, count=0, state=EMPTY, char_received=0, full=0, parallel_out=0, framing_err=0, overrun=0.
REQ-030 rd_req_q SHALL reset to 1 so that rd_req held high through reset does not pop.
REQ-031 Reset asserted mid-operation SHALL discard all entries within one cycle; rx_valid in the reset cycle SHALL be ignored.

Configuration
REQ-032 Macro RX_OVERRUN_FLAG_EN defined: overrun SHALL be set on a dropped character (REQ-022) and held until clr_overrun or rst; set wins over a simultaneous clr_overrun.
REQ-033 Macro RX_OVERRUN_FLAG_EN undefined: no overrun port and no flag logic; clr_overrun SHALL be ignored; dropping behaviour is unchanged.

Structure
REQ-034 Shared package serial_pkg SHALL hold the DATA_W default, the DEPTH default and the status FSM state typedef (EMPTY/PARTIAL/FULL).
REQ-035 The rd_req edge detector SHALL be a sub-module named edge_pulse (clk, rst, level in, pulse out, reset value of the previous sample = 1).

Verification
REQ-036 Single character: after rst, rx_valid with rx_data=8'h41 and rx_stop_bit=1 -> next cycle parallel_out=8'h41, char_received=1, count=1, framing_err=0.
REQ-037 Pop and level handling: rd_req 0->1 and held high 5 cycles -> exactly one pop, count back to 0, char_received=0, parallel_out=0.
REQ-038 Fill and overrun: push 8'h00..8'h08 (9 chars) with DEPTH=8 -> full=1, count=8, 8'h08 dropped, overrun=1 (macro on); pop order 8'h00..8'h07.
REQ-039 Simultaneous push and pop: at full, rx_valid=8'h55 with a pop -> count stays 8, no overrun, 8'h55 appears last after 7 further pops.
REQ-040 Framing tag and empty corner: push 8'h7E with rx_stop_bit=0 -> framing_err=1 while at head; rx_valid and pop together on empty -> count=1.
REQ-041 Reset mid-stream: rst with count=5 and rd_req high -> all outputs at reset values; no pop after rst deasserts while rd_req stays high.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-receive definitions: default character width, buffer depth
// and the status FSM state encoding used by rx_char_buffer.
package serial_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } status_t;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector: one-cycle pulse when level goes 0->1. The previous
// sample resets to 1 so a level already high during reset never fires.
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (rst) level_q <= 1'b1;
    else     level_q <= level;
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/rx_char_buffer.sv
// Show-ahead receive character FIFO with status FSM and framing tag.
// Optional sticky overrun flag enabled by defining RX_OVERRUN_FLAG_EN.
module rx_char_buffer
  import serial_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_stop_bit,
  input  logic                       rd_req,
  input  logic                       clr_overrun,
  output logic [DATA_W-1:0]          parallel_out,
  output logic                       char_received,
  output logic                       framing_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
`ifdef RX_OVERRUN_FLAG_EN
  output logic                       overrun,
`endif
  output status_t                    state_dbg
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; a
  // character offered while full without a same-cycle pop is dropped.
  // Reads are 0->1 edges of rd_req; an edge while empty is discarded.

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [DATA_W:0]    head;
  status_t            state;
  logic               pop_pulse;
  logic               is_empty;
  logic               is_full;
  logic               pop;
  logic               push;
  logic               drop;

  edge_pulse u_rd_edge (
    .clk   (clk),
    .rst   (rst),
    .level (rd_req),
    .pulse (pop_pulse)
  );

  assign is_empty = (state == EMPTY);
  assign is_full  = (state == FULL);
  assign pop      = pop_pulse & ~is_empty;
  assign push     = rx_valid & (~is_full | pop);
  assign drop     = rx_valid & is_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {rx_stop_bit, rx_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      char_received <= 1'b0;
      full          <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state         <= PARTIAL;
            char_received <= 1'b1;
          end
        end
        PARTIAL: begin
          if (pop && !push && count == CNT_W'(1)) begin
            state         <= EMPTY;
            char_received <= 1'b0;
          end else if (push && !pop && count == CNT_W'(DEPTH - 1)) begin
            state <= FULL;
            full  <= 1'b1;
          end
        end
        FULL: begin
          if (pop && !push) begin
            state <= PARTIAL;
            full  <= 1'b0;
          end
        end
        default: begin
          state         <= EMPTY;
          char_received <= 1'b0;
          full          <= 1'b0;
        end
      endcase
    end
  end

  // Memory is not reset, so the head is masked while empty.
  assign head         = mem[rd_ptr];
  assign parallel_out = is_empty ? '0 : head[DATA_W-1:0];
  assign framing_err  = is_empty ? 1'b0 : ~head[DATA_W];
  assign state_dbg    = state;

`ifdef RX_OVERRUN_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)              overrun <= 1'b0;
    else if (drop)        overrun <= 1'b1;
    else if (clr_overrun) overrun <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_overrun | drop;
`endif

endmodule
